// File: rtl/div_unit_if.sv
// Execute-stage divider bus: pipeline-side request/flush and the unit's result/stall signals.
// A request is one held div_start level; it is consumed by the single result_valid pulse.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             result_valid;
  logic             div_stall;
  logic             busy;

  modport master (
    output div_start, div_signed, a, b, flush,
    input  result_hi, result_lo, result_valid, div_stall, busy
  );

  modport slave (
    input  div_start, div_signed, a, b, flush,
    output result_hi, result_lo, result_valid, div_stall, busy
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, HI=remainder, LO=quotient.
// Sign handling is done on magnitudes at acceptance and re-applied when entering DONE.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             sa_q, sb_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             valid_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic             qbit;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] q_fin, r_fin;

    always_comb begin
        a_neg  = bus.div_signed & bus.a[WIDTH-1];
        b_neg  = bus.div_signed & bus.b[WIDTH-1];
        a_mag  = a_neg ? ('0 - bus.a) : bus.a;
        b_mag  = b_neg ? ('0 - bus.b) : bus.b;
        rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        // A set carry bit means the shifted remainder exceeds any WIDTH-bit divisor.
        qbit   = rem_q[WIDTH] | (rem_sh >= {1'b0, dvs_q});
        rem_d  = qbit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        dvd_d  = {dvd_q[WIDTH-2:0], qbit};
        q_fin  = (sa_q ^ sb_q) ? ('0 - dvd_d) : dvd_d;
        r_fin  = sa_q ? ('0 - rem_d[WIDTH-1:0]) : rem_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.div_start) begin
                            sa_q  <= a_neg;
                            sb_q  <= b_neg;
                            dvd_q <= a_mag;
                            dvs_q <= b_mag;
                            rem_q <= '0;
                            cnt_q <= '0;
                            if (b_mag == '0) begin
                                state_q <= S_DONE;
                                lo_q    <= '1;
                                hi_q    <= bus.a;
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(WIDTH - 1)) begin
                            state_q <= S_DONE;
                            hi_q    <= r_fin;
                            lo_q    <= q_fin;
                            valid_q <= 1'b1;
                        end
                    end
                    // div_start here still belongs to the completing instruction.
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.result_hi    = hi_q;
    assign bus.result_lo    = lo_q;
    assign bus.result_valid = valid_q & ~bus.flush;
    assign bus.div_stall    = bus.div_start & ~bus.result_valid & ~bus.flush;
    assign bus.busy         = (state_q != S_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider with its own sequencing FSM. It executes the DIV/DIVU instructions issued by the main decoder in the execute stage and holds the pipeline through `div_stall` until the quotient and remainder are ready. Results go to the HI/LO register write path: HI receives the remainder, LO receives the quotient. The unit drops an in-flight division on pipeline flush (exception or ERET).

## Interface
- `WIDTH`, default 32: operand width; the iteration count equals `WIDTH`.

- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `div_start` input 1: a DIV/DIVU instruction is in EX. Held high by the pipeline while stalled.
- `div_signed` input 1: 1 = DIV (signed), 0 = DIVU. Sampled with `div_start`.
- `a` input WIDTH: dividend (rs). Sampled only on acceptance.
- `b` input WIDTH: divisor (rt). Sampled only on acceptance.
- `flush` input 1: cancel any in-flight division.
- `result_hi` output WIDTH: remainder. Registered.
- `result_lo` output WIDTH: quotient. Registered.
- `result_valid` output 1: high for exactly the one DONE cycle.
- `div_stall` output 1: combinational, `div_start & ~result_valid & ~flush`.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Acceptance:** in IDLE with `div_start`=1 and `flush`=0, the unit latches its operands.
  - It records operand signs `sa`/`sb` only when `div_signed`=1; otherwise both are 0.
  - It latches the magnitudes: |a| and |b| (two's-complement negate when the sign is set).
  - It clears the 6-bit counter and the WIDTH+1-bit partial remainder.
- **Transition from IDLE:**
  - If the divisor magnitude is nonzero, next state is RUN.
  - If the divisor is 0, next state is DONE with `result_lo`=all ones and `result_hi`=`a` (raw operand, regardless of signedness).
- **RUN, one restoring step per cycle:**
  - Shift `{rem, dividend_msb}` left.
  - If `rem_shifted >= |b|`, subtract |b| and shift in quotient bit 1; else shift in 0.
  - Increment the counter.
  - After WIDTH steps (counter reaches WIDTH-1 on the last step), next state is DONE.
- **Entering DONE:** the unit applies signs and registers the results.
  - The quotient is negated when `sa^sb`.
  - The remainder is negated when `sa`.
  - Consequently, the sign of a nonzero remainder equals the dividend's sign.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF signed yields `lo`=0x80000000, `hi`=0. This falls out of the magnitude path and needs no special case.
- **DONE:** `result_valid`=1 and the next state is IDLE unconditionally. `div_start` seen in DONE is not a new request, because it belongs to the completing instruction.
- **Flush:** `flush`=1 in any state forces IDLE next cycle.
  - `result_valid` is suppressed in that cycle.
  - `result_hi`/`result_lo` keep their old values.
  - `flush` has priority over `div_start`.
- **Reset:** `rst` forces IDLE, counter 0, `result_hi`=0, `result_lo`=0, `result_valid`=0, `busy`=0. Reset mid-RUN discards the operation.
- Operand changes on `a`/`b` after acceptance have no effect.

## Timing
- Acceptance at edge of cycle N (IDLE, `div_start`=1).
- **Nonzero divisor:**
  - RUN occupies cycles N+1 .. N+WIDTH.
  - DONE and `result_valid` are in cycle N+WIDTH+1 (N+33 for WIDTH=32).
  - `div_stall` is high in cycles N .. N+WIDTH (33 cycles) and low in cycle N+WIDTH+1.
- **Zero divisor:** DONE is in cycle N+1, and `div_stall` is high for cycle N only.
- Results are stable from the DONE cycle until the next DONE or reset. HI/LO are written by the consumer in the DONE cycle.
- **Back-to-back divides:** the next instruction reaches EX in cycle N+WIDTH+2, when the FSM is in IDLE. It is accepted that cycle with no bubble beyond the stall.
- `busy` is high during RUN and DONE.

## Test plan
- **Unsigned divide:** DIVU a=100, b=7 -> `result_lo`=14, `result_hi`=2, `result_valid` in the 33rd cycle after acceptance, `div_stall` high for exactly 33 cycles.
- **Signed divide:** DIV a=-7 (0xFFFFFFF9), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=7, b=-2 -> `lo`=0xFFFFFFFD, `hi`=1.
- **Divide by zero and overflow:**
  - DIVU a=0x1234, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x1234, valid in cycle N+1.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- **Flush mid-run:** flush at cycle N+10 -> IDLE at N+11, no `result_valid`, outputs unchanged. A new DIVU 9/3 then yields `lo`=3, `hi`=0.
- **Back-to-back:** DIVU 0xFFFFFFFF/1 followed immediately by DIVU 10/3 -> two valid pulses 34 cycles apart. Results are (`lo`=0xFFFFFFFF, `hi`=0) then (`lo`=3, `hi`=1).
- **Reset mid-run:** `rst` at cycle N+5 -> all outputs 0 and `busy`=0 the next cycle, no valid pulse.
